// File: rtl/tcam_update_ctrl.sv
// Whole-slice update controller for the SRL/LUTRAM fractured TCAM: sweeps every chunk address and writes match bitmaps.
// Optional `define TCAM_UPD_SKID_EN adds a one-deep command holding register for back-to-back slice updates.
module tcam_update_ctrl #(
    parameter int TCAM_WIDTH        = 40,
    parameter int TCAM_DEPTH        = 512,
    parameter int ENTRIES_PER_SLICE = 8,
    parameter int CHUNK_WIDTH       = 5,
    localparam int NCHUNK   = TCAM_WIDTH / CHUNK_WIDTH,
    localparam int NSLICE   = TCAM_DEPTH / ENTRIES_PER_SLICE,
    localparam int SLICE_AW = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int CMD_W    = TCAM_WIDTH * ENTRIES_PER_SLICE,
    localparam int ROW_W    = NCHUNK * ENTRIES_PER_SLICE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TCAM_WIDTH-1:0]        search_key,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_op,
    input  logic [SLICE_AW-1:0]          cmd_slice,
    input  logic [ENTRIES_PER_SLICE-1:0] cmd_entry_valid,
    input  logic [CMD_W-1:0]             cmd_data,
    input  logic [CMD_W-1:0]             cmd_keep,
    output logic [TCAM_WIDTH-1:0]        wr_addr,
    output logic [ROW_W-1:0]             wr_data,
    output logic [NSLICE-1:0]            wr_en_oh,
    output logic                         busy,
    output logic                         done,
    output logic                         done_err
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CHUNK_WIDTH-1:0]         r_cnt;
    logic [CHUNK_WIDTH-1:0]         w_cnt_nxt;

    logic                           r_op_p0;
    logic [SLICE_AW-1:0]            r_slice_p0;
    logic [ENTRIES_PER_SLICE-1:0]   r_ev_p0;
    logic [CMD_W-1:0]               r_data_p0;
    logic [CMD_W-1:0]               r_keep_p0;

    logic [TCAM_WIDTH-1:0]          r_wr_addr_p1;
    logic [ROW_W-1:0]               r_wr_data_p1;
    logic [NSLICE-1:0]              r_wr_en_p1;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_done_err;

    logic                           w_accept;
    logic                           w_start;
    logic                           w_src_op;
    logic [SLICE_AW-1:0]            w_src_slice;
    logic [ENTRIES_PER_SLICE-1:0]   w_src_ev;
    logic [CMD_W-1:0]               w_src_data;
    logic [CMD_W-1:0]               w_src_keep;
    logic                           w_src_err;

    logic                           w_act_op;
    logic [SLICE_AW-1:0]            w_act_slice;
    logic [ENTRIES_PER_SLICE-1:0]   w_act_ev;
    logic [CMD_W-1:0]               w_act_data;
    logic [CMD_W-1:0]               w_act_keep;

    function automatic logic [NSLICE-1:0] slice_onehot(input logic [SLICE_AW-1:0] s);
        logic [NSLICE-1:0] v;
        v = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (s == i[SLICE_AW-1:0]) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Bit (c,e) is set when every cared bit of entry e's chunk c equals the sweep address.
    function automatic logic [ROW_W-1:0] row_bits(
        input logic                         op,
        input logic [ENTRIES_PER_SLICE-1:0] ev,
        input logic [CMD_W-1:0]             data,
        input logic [CMD_W-1:0]             keep,
        input logic [CHUNK_WIDTH-1:0]       a
    );
        logic [ROW_W-1:0]       v;
        logic [CHUNK_WIDTH-1:0] d;
        logic [CHUNK_WIDTH-1:0] k;
        v = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            for (int e = 0; e < ENTRIES_PER_SLICE; e++) begin
                d = data[e*TCAM_WIDTH + c*CHUNK_WIDTH +: CHUNK_WIDTH];
                k = keep[e*TCAM_WIDTH + c*CHUNK_WIDTH +: CHUNK_WIDTH];
                v[c*ENTRIES_PER_SLICE + e] = !op && ev[e] && ((k & (d ^ a)) == '0);
            end
        end
        return v;
    endfunction

    assign w_accept = cmd_valid && cmd_ready;

`ifdef TCAM_UPD_SKID_EN
    logic                           r_hold_vld;
    logic                           r_hold_op;
    logic [SLICE_AW-1:0]            r_hold_slice;
    logic [ENTRIES_PER_SLICE-1:0]   r_hold_ev;
    logic [CMD_W-1:0]               r_hold_data;
    logic [CMD_W-1:0]               r_hold_keep;
    logic                           w_hold_load;

    assign cmd_ready = !r_hold_vld && !rst;

    // A held command takes priority at DONE; otherwise a fresh command starts directly or parks in the holder.
    always_comb begin
        w_src_op    = cmd_op;
        w_src_slice = cmd_slice;
        w_src_ev    = cmd_entry_valid;
        w_src_data  = cmd_data;
        w_src_keep  = cmd_keep;
        w_start     = 1'b0;
        w_hold_load = 1'b0;
        if ((r_state == S_DONE) && r_hold_vld) begin
            w_src_op    = r_hold_op;
            w_src_slice = r_hold_slice;
            w_src_ev    = r_hold_ev;
            w_src_data  = r_hold_data;
            w_src_keep  = r_hold_keep;
            w_start     = 1'b1;
        end else if (((r_state == S_IDLE) || (r_state == S_DONE)) && w_accept) begin
            w_start = 1'b1;
        end else if (w_accept) begin
            w_hold_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
        end else if (w_hold_load) begin
            r_hold_vld <= 1'b1;
        end else if ((r_state == S_DONE) && r_hold_vld) begin
            r_hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hold_load) begin
            r_hold_op    <= cmd_op;
            r_hold_slice <= cmd_slice;
            r_hold_ev    <= cmd_entry_valid;
            r_hold_data  <= cmd_data;
            r_hold_keep  <= cmd_keep;
        end
    end
`else
    assign cmd_ready   = (r_state == S_IDLE) && !rst;
    assign w_src_op    = cmd_op;
    assign w_src_slice = cmd_slice;
    assign w_src_ev    = cmd_entry_valid;
    assign w_src_data  = cmd_data;
    assign w_src_keep  = cmd_keep;
    assign w_start     = (r_state == S_IDLE) && w_accept;
`endif

    generate
        if (NSLICE == (1 << SLICE_AW)) begin : g_range_full
            assign w_src_err = 1'b0;
        end else begin : g_range_chk
            assign w_src_err = (int'(w_src_slice) >= NSLICE);
        end
    endgenerate

    assign w_act_op    = w_start ? w_src_op    : r_op_p0;
    assign w_act_slice = w_start ? w_src_slice : r_slice_p0;
    assign w_act_ev    = w_start ? w_src_ev    : r_ev_p0;
    assign w_act_data  = w_start ? w_src_data  : r_data_p0;
    assign w_act_keep  = w_start ? w_src_keep  : r_keep_p0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_src_err ? S_DONE : S_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            S_SWEEP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == '1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_start) begin
                    w_state_nxt = w_src_err ? S_DONE : S_SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p0 -> p1: outputs are registered from next-state values so the first write lands one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
            r_wr_en_p1   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wr_addr_p1 <= {NCHUNK{w_cnt_nxt}};
            r_wr_data_p1 <= (w_state_nxt == S_SWEEP) ?
                            row_bits(w_act_op, w_act_ev, w_act_data, w_act_keep, w_cnt_nxt) : '0;
            r_wr_en_p1   <= (w_state_nxt == S_SWEEP) ? slice_onehot(w_act_slice) : '0;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_done_err   <= (w_state_nxt == S_DONE) && w_start && w_src_err;
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op_p0    <= w_src_op;
            r_slice_p0 <= w_src_slice;
            r_ev_p0    <= w_src_ev;
            r_data_p0  <= w_src_data;
            r_keep_p0  <= w_src_keep;
        end
    end

    assign wr_addr  = (r_state == S_SWEEP) ? r_wr_addr_p1 : search_key;
    assign wr_data  = r_wr_data_p1;
    assign wr_en_oh = r_wr_en_p1;
    assign busy     = r_busy;
    assign done     = r_done;
    assign done_err = r_done_err;

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// Directed bench for tcam_update_ctrl: default-size instance plus a 10-slice instance for range errors.
module tb_tcam_update_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic [39:0]   search_key;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [5:0]    cmd_slice;
    logic [7:0]    cmd_entry_valid;
    logic [319:0]  cmd_data;
    logic [319:0]  cmd_keep;
    logic [39:0]   wr_addr;
    logic [63:0]   wr_data;
    logic [63:0]   wr_en_oh;
    logic          busy, done, done_err;

    logic          r_valid, r_ready;
    logic [3:0]    r_slice;
    logic [39:0]   r_wr_addr;
    logic [63:0]   r_wr_data;
    logic [9:0]    r_wr_en;
    logic          r_busy, r_done, r_done_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tcam_update_ctrl u_dut (
        .clk(clk), .rst(rst), .search_key(search_key),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_slice(cmd_slice), .cmd_entry_valid(cmd_entry_valid),
        .cmd_data(cmd_data), .cmd_keep(cmd_keep),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en_oh(wr_en_oh),
        .busy(busy), .done(done), .done_err(done_err)
    );

    tcam_update_ctrl #(.TCAM_DEPTH(80)) u_rng (
        .clk(clk), .rst(rst), .search_key(search_key),
        .cmd_valid(r_valid), .cmd_ready(r_ready), .cmd_op(cmd_op),
        .cmd_slice(r_slice), .cmd_entry_valid(cmd_entry_valid),
        .cmd_data(cmd_data), .cmd_keep(cmd_keep),
        .wr_addr(r_wr_addr), .wr_data(r_wr_data), .wr_en_oh(r_wr_en),
        .busy(r_busy), .done(r_done), .done_err(r_done_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived row image for the pattern command (entries 0,2,3,5 valid).
    function automatic logic [63:0] pat_row(input int a);
        logic [63:0] v;
        v = 64'h2D2D2D2D2D25292C;
        if (a == 31) v[0] = 1'b1;
        if (a == 10) v[10] = 1'b1;
        if (a >= 20 && a <= 23) v[19] = 1'b1;
        return v;
    endfunction

    task automatic issue(input logic op, input logic [5:0] slice);
        cmd_op = op;
        cmd_slice = slice;
        cmd_valid = 1'b1;
        #1;
        for (int n = 0; n < 200 && !cmd_ready; n++) step();
        chk("issue_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_sweep(input logic [5:0] slice, input bit clr);
        logic [4:0] a5;
        for (int a = 0; a < 32; a++) begin
            a5 = 5'(a);
            chk("sweep_wr_en", wr_en_oh, 64'd1 << slice);
            chk("sweep_wr_data", wr_data, clr ? 64'd0 : pat_row(a));
            chk("sweep_wr_addr", wr_addr, {8{a5}});
            chk("sweep_busy", busy, 1);
            chk("sweep_done", done, 0);
            step();
        end
        chk("done_pulse", done, 1);
        chk("done_err", done_err, 0);
        chk("done_busy", busy, 1);
        chk("done_wr_en", wr_en_oh, 0);
`ifdef TCAM_UPD_SKID_EN
        chk("done_ready", cmd_ready, 1);
`else
        chk("done_ready", cmd_ready, 0);
`endif
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_addr", wr_addr, 40'hFF000000A5);
    endtask

    initial begin
        int acc2, w2, d1, d2, busy_low, ndone;
        rst = 1'b1;
        cmd_valid = 1'b0;
        r_valid = 1'b0;
        cmd_op = 1'b0;
        cmd_slice = '0;
        r_slice = '0;
        cmd_entry_valid = '0;
        cmd_data = '0;
        cmd_keep = '0;
        search_key = 40'h123456789A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en_oh, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_ready_rng", r_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1);
        chk("idle_key_fwd0", wr_addr, 40'h123456789A);
        search_key = 40'hFF000000A5;
        #1;
        chk("idle_key_fwd1", wr_addr, 40'hFF000000A5);
        step();

        // Pattern: entry0 exact on chunk0, entry2 exact on chunk1, entry3 partial on chunk2, entry5 all don't-care.
        cmd_entry_valid = 8'h2D;
        cmd_data[0*40 +: 40] = 40'h000000001F;  cmd_keep[0*40 +: 40] = 40'h000000001F;
        cmd_data[2*40 +: 40] = 40'h0000000140;  cmd_keep[2*40 +: 40] = 40'h00000003E0;
        cmd_data[3*40 +: 40] = 40'h0000005000;  cmd_keep[3*40 +: 40] = 40'h0000007000;
        cmd_data[5*40 +: 40] = 40'hABCDEF0123;  cmd_keep[5*40 +: 40] = 40'h0000000000;
        issue(1'b0, 6'd3);
        run_sweep(6'd3, 1'b0);

        cmd_entry_valid = 8'hFF;
        issue(1'b1, 6'd63);
        run_sweep(6'd63, 1'b1);

        // Range check on the 10-slice instance: slice 10 errors at T+1, slice 9 sweeps.
        r_slice = 4'd10;
        r_valid = 1'b1;
        #1;
        chk("rng_ready", r_ready, 1);
        step();
        r_valid = 1'b0;
        chk("rng_err_done", r_done, 1);
        chk("rng_err_flag", r_done_err, 1);
        chk("rng_err_wr_en", r_wr_en, 0);
        chk("rng_err_busy", r_busy, 1);
        step();
        chk("rng_err_done_clr", r_done, 0);
        chk("rng_err_idle", r_busy, 0);
        chk("rng_err_ready", r_ready, 1);
        r_slice = 4'd9;
        r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        chk("rng_last_wr_en", r_wr_en, 10'h200);
        chk("rng_last_done", r_done, 0);
        repeat (32) step();
        chk("rng_last_done_pulse", r_done, 1);
        chk("rng_last_done_err", r_done_err, 0);
        step();

        // Reset in the middle of a sweep.
        cmd_entry_valid = 8'h2D;
        issue(1'b0, 6'd5);
        repeat (10) step();
        chk("mid_addr_a10", wr_addr, {8{5'd10}});
        chk("mid_data_a10", wr_data, pat_row(10));
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_en_oh, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            step();
        end
        chk("mid_rst_no_done", ndone, 0);
        issue(1'b0, 6'd5);
        run_sweep(6'd5, 1'b0);

        // Two commands offered back to back.
        acc2 = -1; w2 = -1; d1 = -1; d2 = -1; busy_low = 0;
        issue(1'b1, 6'd1);
        cmd_op = 1'b1;
        cmd_slice = 6'd2;
        cmd_valid = 1'b1;
        #1;
        for (int k = 1; k < 120; k++) begin
            if (acc2 < 0 && cmd_ready) acc2 = k;
            if (w2 < 0 && wr_en_oh == 64'd4) w2 = k;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k <= 60 && !busy) busy_low++;
            @(posedge clk);
            #1;
            if (acc2 == k) cmd_valid = 1'b0;
            #1;
        end
        cmd_valid = 1'b0;
        chk("b2b_done1", d1, 33);
`ifdef TCAM_UPD_SKID_EN
        chk("b2b_accept2", acc2, 1);
        chk("b2b_first_write2", w2, 34);
        chk("b2b_done2", d2, 66);
        chk("b2b_busy_gaps", busy_low, 0);
`else
        chk("b2b_accept2", acc2, 34);
        chk("b2b_first_write2", w2, 35);
        chk("b2b_done2", d2, 67);
        chk("b2b_busy_gaps", busy_low, 1);
`endif
        chk("b2b_end_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
